tdm_demux: RTL and testbench

//  Receive end of the time-division link whose send end is a Mux-tree serializer.

---
 rtl/tdm_demux_pkg.sv | 22 ++
 rtl/tdm_demux_if.sv | 45 ++++
 rtl/tdm_demux_dmux.sv | 27 ++
 rtl/tdm_demux.sv | 129 ++++++++++++
 tb/tb_tdm_demux.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/tdm_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux_pkg
// Description : Shared definitions for the TDM link (demux receive end and
//               future mux serializer): FSM state encodings and default
//               word width / frame size.
// Revision    : 1.0  initial release
// ============================================================================
package tdm_demux_pkg;

    // Default Hack word width and slots per frame
    localparam int DEF_WIDTH    = 16;
    localparam int DEF_CHANNELS = 8;

    // Framing state machine encodings
    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } tdm_state_e;

endpackage : tdm_demux_pkg
`default_nettype wire

// File: rtl/tdm_demux_if.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux_if
// Description : Link-side and channel-side signals of the TDM demux.
//               master : the link driver (drives in_*, err_clr)
//               slave  : the demux (drives out_*, frame_done, locked, sync_err)
//   in_valid   word valid this cycle, always accepted
//   in_sync    marks slot 0 word
//   in_data    slot word
//   err_clr    clears sticky sync_err
//   out_data   channel k at [k*WIDTH +: WIDTH]
//   out_load   one-hot per-channel update strobe
//   frame_done complete error-free frame landed
//   locked     framer is locked
//   sync_err   sticky framing error
// Revision    : 1.0  initial release
// ============================================================================
interface tdm_demux_if
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
);
    logic                      in_valid;
    logic                      in_sync;
    logic [WIDTH-1:0]          in_data;
    logic                      err_clr;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic [CHANNELS-1:0]       out_load;
    logic                      frame_done;
    logic                      locked;
    logic                      sync_err;

    modport master (
        output in_valid, in_sync, in_data, err_clr,
        input  out_data, out_load, frame_done, locked, sync_err
    );

    modport slave (
        input  in_valid, in_sync, in_data, err_clr,
        output out_data, out_load, frame_done, locked, sync_err
    );

endinterface : tdm_demux_if
`default_nettype wire

// File: rtl/tdm_demux_dmux.sv
`default_nettype none
// ============================================================================
// Module      : dmux_onehot
// Description : Combinational select decoder: turns a slot index plus an
//               enable into a one-hot channel load vector.
//   sel   slot index
//   en    write enable; all-zero output when low
//   load  one-hot load vector
// Revision    : 1.0  initial release
// ============================================================================
module dmux_onehot
    import tdm_demux_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic [$clog2(CHANNELS)-1:0] sel,
    input  logic                        en,
    output logic [CHANNELS-1:0]         load
);
    localparam int SEL_W = $clog2(CHANNELS);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_dec
        assign load[k] = en && (sel == SEL_W'(k));
    end

endmodule : dmux_onehot
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux
// Description : Receive end of the TDM link. Tracks slot position from the
//               slot-0 sync flag and steers each accepted word into its
//               channel holding register one cycle later.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         tdm_demux_if slave modport (link inputs, channel outputs)
// Revision    : 1.0  initial release
// ============================================================================
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic       clk,
    input  logic       rst_n,
    tdm_demux_if.slave bus
);
    localparam int SEL_W = $clog2(CHANNELS);

    localparam logic [SEL_W-1:0] c_slot0     = '0;
    localparam logic [SEL_W-1:0] c_slot1     = SEL_W'(1);
    localparam logic [SEL_W-1:0] c_last_slot = SEL_W'(CHANNELS - 1);

    tdm_state_e                r_state;
    logic [SEL_W-1:0]          r_cnt;
    logic [CHANNELS*WIDTH-1:0] r_data;
    logic [CHANNELS-1:0]       r_load;
    logic                      r_frame_done;
    logic                      r_sync_err;

    tdm_state_e                w_state_nxt;
    logic [SEL_W-1:0]          w_cnt_nxt;
    logic [SEL_W-1:0]          w_sel;
    logic                      w_write;
    logic                      w_set_err;
    logic                      w_done;
    logic [CHANNELS-1:0]       w_load;

    // Framing decode for the current beat
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel       = c_slot0;
        w_write     = 1'b0;
        w_set_err   = 1'b0;
        w_done      = 1'b0;
        if (bus.in_valid) begin
            if (r_state == ST_HUNT) begin
                if (bus.in_sync) begin
                    w_write     = 1'b1;
                    w_cnt_nxt   = c_slot1;
                    w_state_nxt = ST_LOCKED;
                end
            end else if (r_cnt == c_slot0) begin
                if (bus.in_sync) begin
                    w_write   = 1'b1;
                    w_cnt_nxt = c_slot1;
                end else begin
                    // Missing sync: drop word and fall back to hunting
                    w_set_err   = 1'b1;
                    w_cnt_nxt   = c_slot0;
                    w_state_nxt = ST_HUNT;
                end
            end else if (!bus.in_sync) begin
                w_write   = 1'b1;
                w_sel     = r_cnt;
                w_cnt_nxt = r_cnt + c_slot1;
                // In-order path only reaches the last slot after a sync
                // and every slot in between, so the frame is complete.
                w_done    = (r_cnt == c_last_slot);
            end else begin
                // Early sync: abandon partial frame, restart at slot 0
                w_set_err = 1'b1;
                w_write   = 1'b1;
                w_cnt_nxt = c_slot1;
            end
        end
    end

    dmux_onehot #(
        .CHANNELS (CHANNELS)
    ) u_dmux (
        .sel  (w_sel),
        .en   (w_write),
        .load (w_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_HUNT;
            r_cnt        <= '0;
            r_load       <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_load       <= w_load;
            r_frame_done <= w_done;
            // Set has priority over clear
            if (w_set_err) begin
                r_sync_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_sync_err <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data[k*WIDTH +: WIDTH] <= '0;
            end else if (w_load[k]) begin
                r_data[k*WIDTH +: WIDTH] <= bus.in_data;
            end
        end
    end

    assign bus.out_data   = r_data;
    assign bus.out_load   = r_load;
    assign bus.frame_done = r_frame_done;
    assign bus.locked     = (r_state == ST_LOCKED);
    assign bus.sync_err   = r_sync_err;

endmodule : tdm_demux
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_demux
// Description : Self-checking bench for tdm_demux (WIDTH=16, CHANNELS=8).
// Revision    : 1.0  initial release
// ============================================================================
module tb_tdm_demux;

    localparam int WIDTH    = 16;
    localparam int CHANNELS = 8;

    logic clk;
    logic rst_n;

    tdm_demux_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

    tdm_demux #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic [7:0]   load;
        logic         done;
        logic         locked;
        logic         err;
    } exp_t;

    typedef struct {
        logic        v;
        logic        s;
        logic [15:0] d;
        logic [7:0]  load;
        logic        done;
        logic        lk;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[11];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic         m_locked;
    int           m_next;
    logic [127:0] m_data;
    logic         m_err;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endfunction

    function automatic void model_reset();
        m_locked = 1'b0;
        m_next   = 0;
        m_data   = '0;
        m_err    = 1'b0;
    endfunction

    // Predict outputs following one beat and push them to the scoreboard
    function automatic void model_step(logic v, logic s, logic [15:0] d, logic clr);
        exp_t e;
        logic err_set = 1'b0;
        e.load = '0;
        e.done = 1'b0;
        if (v) begin
            if (s) begin
                if (m_locked && m_next != 0) err_set = 1'b1;
                m_data[15:0] = d;
                e.load       = 8'h01;
                m_locked     = 1'b1;
                m_next       = 1;
            end else if (m_locked) begin
                if (m_next == 0) begin
                    err_set  = 1'b1;
                    m_locked = 1'b0;
                end else begin
                    m_data[m_next*16 +: 16] = d;
                    e.load = 8'h01 << m_next;
                    e.done = (m_next == CHANNELS - 1);
                    m_next = (m_next + 1) % CHANNELS;
                end
            end
        end
        if (err_set) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        e.data   = m_data;
        e.locked = m_locked;
        e.err    = m_err;
        sb.push_back(e);
    endfunction

    task automatic drive(input logic v, input logic s, input logic [15:0] d, input logic clr);
        exp_t e;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_sync  = s;
        bus.in_data  = d;
        bus.err_clr  = clr;
        model_step(v, s, d, clr);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard: got empty queue, want entry");
        end else begin
            e = sb.pop_front();
            check("sb_data",   bus.out_data,   e.data);
            check("sb_load",   bus.out_load,   e.load);
            check("sb_done",   bus.frame_done, e.done);
            check("sb_locked", bus.locked,     e.locked);
            check("sb_err",    bus.sync_err,   e.err);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic send_frame(input logic [15:0] base, input int max_gap);
        for (int k = 0; k < CHANNELS; k++) begin
            drive(1'b1, (k == 0), base + 16'(k), 1'b0);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    logic [127:0] clean_img;

    initial begin
        // Table: three HUNT discards then a clean back-to-back frame
        tbl[0] = '{1'b1, 1'b0, 16'hAAAA, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 16'hBBBB, 8'h00, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 16'hCCCC, 8'h00, 1'b0, 1'b0};
        for (int k = 0; k < 8; k++)
            tbl[3+k] = '{1'b1, (k == 0), 16'h1000 + 16'(k), 8'h01 << k, (k == 7), 1'b1};
        for (int k = 0; k < 8; k++) clean_img[k*16 +: 16] = 16'h1000 + 16'(k);

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        bus.in_data  = '0;
        bus.err_clr  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_data",   bus.out_data,   128'h0);
        check("rst_load",   bus.out_load,   8'h00);
        check("rst_done",   bus.frame_done, 1'b0);
        check("rst_locked", bus.locked,     1'b0);
        check("rst_err",    bus.sync_err,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // HUNT discard + clean frame
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].d, 1'b0);
            check("tbl_load",   bus.out_load,   tbl[i].load);
            check("tbl_done",   bus.frame_done, tbl[i].done);
            check("tbl_locked", bus.locked,     tbl[i].lk);
            if (i < 3) check("tbl_hunt_data", bus.out_data, 128'h0);
        end
        check("clean_image", bus.out_data, clean_img);

        // Gapped frame with same words
        send_frame(16'h1000, 3);
        check("gapped_image", bus.out_data, clean_img);

        // Early sync at slot 5
        for (int k = 0; k < 5; k++) drive(1'b1, (k == 0), 16'h3000 + 16'(k), 1'b0);
        drive(1'b1, 1'b1, 16'h2000, 1'b0);
        check("early_err",    bus.sync_err,          1'b1);
        check("early_locked", bus.locked,            1'b1);
        check("early_ch0",    bus.out_data[15:0],    16'h2000);
        check("early_done",   bus.frame_done,        1'b0);
        for (int k = 1; k < 8; k++) drive(1'b1, 1'b0, 16'h2000 + 16'(k), 1'b0);
        send_frame(16'h4000, 1);

        // Missing sync after slot 7
        drive(1'b1, 1'b0, 16'hDEAD, 1'b0);
        check("miss_locked", bus.locked,   1'b0);
        check("miss_err",    bus.sync_err, 1'b1);
        check("miss_load",   bus.out_load, 8'h00);
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        check("clr_err", bus.sync_err, 1'b0);
        // Error and clear in the same cycle
        drive(1'b1, 1'b1, 16'h5000, 1'b0);
        drive(1'b1, 1'b1, 16'h5100, 1'b1);
        check("clr_vs_set_err", bus.sync_err, 1'b1);
        drive(1'b0, 1'b0, 16'h0, 1'b1);

        // Asynchronous reset mid-frame
        drive(1'b1, 1'b0, 16'h5101, 1'b0);
        drive(1'b1, 1'b0, 16'h5102, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_data",   bus.out_data,   128'h0);
        check("mrst_load",   bus.out_load,   8'h00);
        check("mrst_locked", bus.locked,     1'b0);
        check("mrst_err",    bus.sync_err,   1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 16'h7777, 1'b0);
        check("post_rst_load", bus.out_load, 8'h00);
        send_frame(16'h6000, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_tdm_demux
`default_nettype wire
